program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the CPU external address width.
REQ-002 Parameter DATA_W, default 16, SHALL set the CPU data word width; it is fixed at 2 bytes.
REQ-003 CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST  in  1  SHALL be the reset: synchronous and active-high.
REQ-005 START  in  1  SHALL be a one-cycle load request.
REQ-006 LEN  in  ADDR_W+1  SHALL be the word count, sampled on an accepted START; range 0..2^ADDR_W.
REQ-007 ABORT  in  1  SHALL cancel an in-progress load.
REQ-008 BYTE_I  in  8  SHALL be the streamed image byte.
REQ-009 BYTE_VALID  in  1 and BYTE_READY  out  1 SHALL form the byte handshake; a byte transfers when both are 1.
REQ-010 EXT_ADDR  out  ADDR_W  SHALL be the CPU memory write address.
REQ-011 DATA_I  out  DATA_W  SHALL be the word written to the CPU.
REQ-012 MEM_WE  out  1  SHALL be the one-cycle CPU memory write strobe.
REQ-013 CPU_HOLD  out  1  SHALL hold the CPU in reset while 1.
REQ-014 DONE  out  1 and ERR  out  1 SHALL be the completion pulse and the sticky error flag.

Function
REQ-015 The block SHALL use these states: IDLE, LOAD_HI, LOAD_LO, WRITE, CHK_HI, CHK_LO, FINISH.
REQ-016 BYTE_READY SHALL be 1 only in LOAD_HI, LOAD_LO, CHK_HI and CHK_LO.
REQ-017 START in IDLE with LEN>0 SHALL:
- latch LEN;
- clear the address counter and ERR;
- set CPU_HOLD=1;
- enter LOAD_HI.
REQ-018 START in IDLE with LEN=0 SHALL pulse DONE for one cycle, leave CPU_HOLD unchanged and stay in IDLE.
REQ-019 START outside IDLE SHALL be ignored.
REQ-020 LOAD_HI SHALL capture the high byte on transfer and enter LOAD_LO; LOAD_LO SHALL capture the low byte and enter WRITE.
REQ-021 WRITE SHALL last exactly one cycle with:
- MEM_WE=1;
- EXT_ADDR=counter;
- DATA_I={high,low}.
The write cycle therefore follows the low-byte transfer by one cycle, giving a peak rate of 2 bytes per 3 cycles.
REQ-022 Outside WRITE, MEM_WE SHALL be 0 and EXT_ADDR/DATA_I SHALL hold their last values.
REQ-023 From WRITE, when counter=LEN-1 the block SHALL go to FINISH (or CHK_HI per REQ-030); otherwise it SHALL increment the counter and return to LOAD_HI. The counter SHALL never wrap; LEN=2^ADDR_W ends at address 2^ADDR_W-1.
REQ-024 FINISH SHALL set CPU_HOLD=0, pulse DONE for one cycle and return to IDLE.
REQ-025 ABORT in any non-IDLE state SHALL:
- enter IDLE the next cycle;
- set ERR=1;
- keep CPU_HOLD=1, so a partial image never runs.
ABORT takes priority over a simultaneous byte transfer or write, and that byte or write is discarded.
REQ-026 ERR SHALL remain 1 until the next accepted START or RST.

Reset
REQ-027 RST SHALL force IDLE, clear the counter and high/low registers, and set EXT_ADDR=0, DATA_I=0, MEM_WE=0, BYTE_READY=0, CPU_HOLD=0, DONE=0, ERR=0.
REQ-028 RST mid-load SHALL abandon the load with no further MEM_WE; RST takes priority over all inputs.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN SHALL, when defined, keep a 16-bit running sum, modulo 2^16, of every word written.
REQ-030 With LOADER_CHECKSUM_EN defined:
- after the last WRITE the block SHALL receive one checksum word via CHK_HI/CHK_LO;
- on a match it SHALL go to FINISH;
- on a mismatch it SHALL set ERR=1, keep CPU_HOLD=1, give no DONE pulse and return to IDLE.
REQ-031 Without LOADER_CHECKSUM_EN, CHK_HI/CHK_LO and the accumulator SHALL be absent and WRITE SHALL go directly to FINISH.

Structure
REQ-032 Package loader_pkg SHALL hold the state enumeration and the ADDR_W/DATA_W default constants.
REQ-033 Sub-module loader_cksum, the 16-bit accumulator with clear/add/compare, SHALL be instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-034 LEN=3, bytes 12 34 AB CD 00 01 streamed back-to-back -> writes 0x1234@0, 0xABCD@1, 0x0001@2; DONE on the cycle after FINISH entry; CPU_HOLD 1 -> 0.
REQ-035 LEN=0 START -> DONE pulse one cycle later; MEM_WE never 1; CPU_HOLD stays 0.
REQ-036 LEN=4, ABORT after the 5th byte -> exactly 2 writes; ERR=1; CPU_HOLD=1; a second START clears ERR.
REQ-037 LOADER_CHECKSUM_EN, words 0xFFFF, 0x0002, checksum 0x0001 -> DONE, ERR=0; with checksum 0x0002 -> ERR=1, no DONE, CPU_HOLD=1.
REQ-038 BYTE_VALID toggled randomly, LEN=2048 -> last write at EXT_ADDR=0x7FF with no wrap; RST asserted mid-load -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader.
// Holds the FSM state encoding and the default bus widths.
package loader_pkg;

  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    LOAD_LO = 3'd2,
    WRITE   = 3'd3,
    FINISH  = 3'd4
`ifdef LOADER_CHECKSUM_EN
    ,
    CHK_HI  = 3'd5,
    CHK_LO  = 3'd6
`endif
  } state_t;

endpackage

// File: rtl/loader_cksum.sv
// 16-bit modulo-2^16 running sum of written words.
// Ports: CLK, RST, clr, add, din, cmp -> match (sum == cmp).
module loader_cksum (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic        add,
  input  logic [15:0] din,
  input  logic [15:0] cmp,
  output logic        match
);

  logic [15:0] sum_q;

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      sum_q <= '0;
    end else if (add) begin
      sum_q <= sum_q + din;
    end
  end

  assign match = (sum_q == cmp);

endmodule

// File: rtl/program_loader.sv
// Streams a byte image into CPU memory as 16-bit words, holding the CPU in reset.
// Ports: CLK, RST, START, LEN, ABORT, BYTE_I/BYTE_VALID/BYTE_READY ->
//   EXT_ADDR, DATA_I, MEM_WE, CPU_HOLD, DONE, ERR.
// Option: define LOADER_CHECKSUM_EN to require a trailing checksum word.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W:0]   LEN,
  input  logic              ABORT,
  input  logic [7:0]        BYTE_I,
  input  logic              BYTE_VALID,
  output logic              BYTE_READY,
  output logic [ADDR_W-1:0] EXT_ADDR,
  output logic [DATA_W-1:0] DATA_I,
  output logic              MEM_WE,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              ERR
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W:0]   len_q;
  logic [7:0]        hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;

  logic              ready;
  logic              we;
  logic              xfer;
  logic              last;
  logic              abort_act;
  logic              go;

  assign xfer      = BYTE_VALID && ready;
  assign last      = ({1'b0, cnt_q} == (len_q - 1'b1));
  assign abort_act = ABORT && (state_q != IDLE);
  assign go        = START && (state_q == IDLE)
                     && (LEN != '0);

`ifdef LOADER_CHECKSUM_EN
  logic ck_match;

  loader_cksum u_cksum (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (go),
    .add   (we),
    .din   (data_q),
    .cmp   ({hi_q, BYTE_I}),
    .match (ck_match)
  );
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = LOAD_HI;
      end
      LOAD_HI: begin
        ready = 1'b1;
        if (BYTE_VALID) state_d = LOAD_LO;
      end
      LOAD_LO: begin
        ready = 1'b1;
        if (BYTE_VALID) state_d = WRITE;
      end
      WRITE: begin
        we = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        state_d = last ? CHK_HI : LOAD_HI;
`else
        state_d = last ? FINISH : LOAD_HI;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK_HI: begin
        ready = 1'b1;
        if (BYTE_VALID) state_d = CHK_LO;
      end
      CHK_LO: begin
        ready = 1'b1;
        if (BYTE_VALID) begin
          state_d = ck_match ? FINISH : IDLE;
        end
      end
`endif
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort wins over any transfer or write this cycle.
    if (abort_act) begin
      state_d = IDLE;
      we      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      len_q  <= '0;
      hi_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      hold_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_act) begin
        // CPU stays held so a partial image never runs.
        err_q <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (go) begin
              len_q  <= LEN;
              cnt_q  <= '0;
              err_q  <= 1'b0;
              hold_q <= 1'b1;
            end else if (START) begin
              done_q <= 1'b1;
            end
          end
          LOAD_HI: begin
            if (xfer) hi_q <= BYTE_I;
          end
          LOAD_LO: begin
            if (xfer) begin
              data_q <= {hi_q, BYTE_I};
              addr_q <= cnt_q;
            end
          end
          WRITE: begin
            if (!last) cnt_q <= cnt_q + 1'b1;
          end
`ifdef LOADER_CHECKSUM_EN
          CHK_HI: begin
            if (xfer) hi_q <= BYTE_I;
          end
          CHK_LO: begin
            if (xfer && !ck_match) err_q <= 1'b1;
          end
`endif
          FINISH: begin
            hold_q <= 1'b0;
            done_q <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign BYTE_READY = ready;
  assign MEM_WE     = we && !RST;
  assign EXT_ADDR   = addr_q;
  assign DATA_I     = data_q;
  assign CPU_HOLD   = hold_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
// Honours LOADER_CHECKSUM_EN when defined.
module tb_program_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [11:0] LEN;
  logic        ABORT;
  logic [7:0]  BYTE_I;
  logic        BYTE_VALID;
  logic        BYTE_READY;
  logic [10:0] EXT_ADDR;
  logic [15:0] DATA_I;
  logic        MEM_WE;
  logic        CPU_HOLD;
  logic        DONE;
  logic        ERR;

  int checks = 0;
  int errors = 0;

  logic [10:0] log_a [0:8191];
  logic [15:0] log_d [0:8191];
  int nw = 0;
  int nd = 0;

  program_loader dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .LEN        (LEN),
    .ABORT      (ABORT),
    .BYTE_I     (BYTE_I),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_READY (BYTE_READY),
    .EXT_ADDR   (EXT_ADDR),
    .DATA_I     (DATA_I),
    .MEM_WE     (MEM_WE),
    .CPU_HOLD   (CPU_HOLD),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (MEM_WE === 1'b1) begin
      if (nw < 8192) begin
        log_a[nw] = EXT_ADDR;
        log_d[nw] = DATA_I;
      end
      nw = nw + 1;
    end
    if (DONE === 1'b1) nd = nd + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    BYTE_I = b;
    BYTE_VALID = 1'b1;
    while (BYTE_READY !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
    tick();
    BYTE_VALID = 1'b0;
  endtask

  task automatic finish_ok(input logic [15:0] sum);
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum[15:8]);
    send_byte(sum[7:0]);
`else
    chk("no_cksum_sum", 32'(sum), 32'(sum));
    tick();
    chk("finish_no_ready", 32'(BYTE_READY), 32'd0);
`endif
    tick();
  endtask

  function automatic logic [15:0] pat(input int i);
    logic [15:0] v;
    v = 16'(i) * 16'h9E37 + 16'h1234;
    return v;
  endfunction

  initial begin
    int base;
    int dbase;
    int bad;
    int gap;
    logic [15:0] w;
    logic [15:0] sum;

    RST = 1'b1;
    START = 1'b0;
    LEN = '0;
    ABORT = 1'b0;
    BYTE_I = '0;
    BYTE_VALID = 1'b0;
    tick();
    tick();
    chk("rst_addr", 32'(EXT_ADDR), 32'd0);
    chk("rst_data", 32'(DATA_I), 32'd0);
    chk("rst_we", 32'(MEM_WE), 32'd0);
    chk("rst_ready", 32'(BYTE_READY), 32'd0);
    chk("rst_hold", 32'(CPU_HOLD), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    RST = 1'b0;
    tick();

    // Three-word load, back-to-back bytes.
    base = nw;
    dbase = nd;
    START = 1'b1;
    LEN = 12'd3;
    tick();
    START = 1'b0;
    chk("l3_hold", 32'(CPU_HOLD), 32'd1);
    chk("l3_ready", 32'(BYTE_READY), 32'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("l3_we0", 32'(MEM_WE), 32'd1);
    chk("l3_addr0", 32'(EXT_ADDR), 32'd0);
    chk("l3_data0", 32'(DATA_I), 32'h1234);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h00);
    send_byte(8'h01);
    chk("l3_addr2", 32'(EXT_ADDR), 32'd2);
    chk("l3_data2", 32'(DATA_I), 32'h0001);
    chk("l3_hold_mid", 32'(CPU_HOLD), 32'd1);
    finish_ok(16'hBE02);
    chk("l3_done", 32'(DONE), 32'd1);
    chk("l3_hold_end", 32'(CPU_HOLD), 32'd0);
    chk("l3_err", 32'(ERR), 32'd0);
    tick();
    chk("l3_done_pulse", 32'(DONE), 32'd0);
    chk("l3_nwrites", 32'(nw - base), 32'd3);
    chk("l3_w1", {5'd0, log_a[base+1], log_d[base+1]},
        {5'd0, 11'd1, 16'hABCD});
    chk("l3_w2", {5'd0, log_a[base+2], log_d[base+2]},
        {5'd0, 11'd2, 16'h0001});
    chk("l3_ndone", 32'(nd - dbase), 32'd1);

    // Zero-length request.
    base = nw;
    START = 1'b1;
    LEN = 12'd0;
    tick();
    START = 1'b0;
    chk("l0_done", 32'(DONE), 32'd1);
    chk("l0_hold", 32'(CPU_HOLD), 32'd0);
    chk("l0_ready", 32'(BYTE_READY), 32'd0);
    tick();
    chk("l0_done_pulse", 32'(DONE), 32'd0);
    tick();
    chk("l0_nwrites", 32'(nw - base), 32'd0);

    // Abort after the fifth byte of a four-word load.
    base = nw;
    START = 1'b1;
    LEN = 12'd4;
    tick();
    START = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    ABORT = 1'b1;
    BYTE_VALID = 1'b1;
    BYTE_I = 8'h66;
    tick();
    ABORT = 1'b0;
    BYTE_VALID = 1'b0;
    chk("ab_err", 32'(ERR), 32'd1);
    chk("ab_hold", 32'(CPU_HOLD), 32'd1);
    chk("ab_ready", 32'(BYTE_READY), 32'd0);
    tick();
    tick();
    chk("ab_nwrites", 32'(nw - base), 32'd2);
    chk("ab_err_sticky", 32'(ERR), 32'd1);
    START = 1'b1;
    LEN = 12'd2;
    tick();
    START = 1'b0;
    chk("ab_restart_err", 32'(ERR), 32'd0);
    chk("ab_restart_hold", 32'(CPU_HOLD), 32'd1);
    // Abort coinciding with the write cycle drops the write.
    base = nw;
    send_byte(8'h77);
    send_byte(8'h88);
    ABORT = 1'b1;
    #1;
    chk("ab_wr_we", 32'(MEM_WE), 32'd0);
    tick();
    ABORT = 1'b0;
    tick();
    chk("ab_wr_nwrites", 32'(nw - base), 32'd0);
    chk("ab_wr_err", 32'(ERR), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match: 0xFFFF + 0x0002 = 0x0001.
    dbase = nd;
    START = 1'b1;
    LEN = 12'd2;
    tick();
    START = 1'b0;
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    tick();
    chk("ck_ok_done", 32'(DONE), 32'd1);
    chk("ck_ok_err", 32'(ERR), 32'd0);
    chk("ck_ok_hold", 32'(CPU_HOLD), 32'd0);
    // Checksum mismatch.
    dbase = nd;
    START = 1'b1;
    tick();
    START = 1'b0;
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h02);
    chk("ck_bad_err", 32'(ERR), 32'd1);
    chk("ck_bad_hold", 32'(CPU_HOLD), 32'd1);
    tick();
    tick();
    chk("ck_bad_ndone", 32'(nd - dbase), 32'd0);
`endif

    // Full 2048-word load with random valid gaps.
    base = nw;
    dbase = nd;
    sum = '0;
    START = 1'b1;
    LEN = 12'd2048;
    tick();
    START = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      w = pat(i);
      sum = sum + w;
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      send_byte(w[15:8]);
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      send_byte(w[7:0]);
    end
    chk("big_last_we", 32'(MEM_WE), 32'd1);
    chk("big_last_addr", 32'(EXT_ADDR), 32'h7FF);
    finish_ok(sum);
    chk("big_done", 32'(DONE), 32'd1);
    chk("big_hold", 32'(CPU_HOLD), 32'd0);
    chk("big_nwrites", 32'(nw - base), 32'd2048);
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (base + i < 8192) begin
        if (log_a[base+i] !== 11'(i) ||
            log_d[base+i] !== pat(i)) bad++;
      end
    end
    chk("big_contents", 32'(bad), 32'd0);

    // Reset in the middle of a load.
    base = nw;
    START = 1'b1;
    LEN = 12'd5;
    tick();
    START = 1'b0;
    send_byte(8'hC0);
    send_byte(8'hDE);
    send_byte(8'hAA);
    RST = 1'b1;
    BYTE_VALID = 1'b1;
    BYTE_I = 8'hBB;
    tick();
    BYTE_VALID = 1'b0;
    chk("mr_addr", 32'(EXT_ADDR), 32'd0);
    chk("mr_data", 32'(DATA_I), 32'd0);
    chk("mr_we", 32'(MEM_WE), 32'd0);
    chk("mr_ready", 32'(BYTE_READY), 32'd0);
    chk("mr_hold", 32'(CPU_HOLD), 32'd0);
    chk("mr_done", 32'(DONE), 32'd0);
    chk("mr_err", 32'(ERR), 32'd0);
    RST = 1'b0;
    tick();
    tick();
    tick();
    chk("mr_nwrites", 32'(nw - base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
